// File: rtl/squeeze_streamer_pkg.sv
// Shared definitions for the squeeze-side output streamer.
// Holds the FSM state type, the Keccak lane width and the SHAKE rate
// constants used by the streamer, its mask generator and the bench.
package squeeze_streamer_pkg;

  localparam int W_LANE         = 64;
  localparam int RATE_SHAKE128  = 1344;
  localparam int RATE_SHAKE256  = 1088;
  localparam int MAX_RATE_WORDS = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SQUEEZE,
    ST_PERMUTE,
    ST_WAIT_PERM
  } squeeze_state_t;

endpackage

// File: rtl/squeeze_streamer_word_mask_gen.sv
// word_mask_gen: combinational mask for the final, possibly partial, word.
// Ports:
//   remaining - output bits still owed to the sink (WIDTH bits)
//   mask      - W-bit mask keeping the low `remaining` bits, all ones when
//               remaining >= W
module word_mask_gen
  import squeeze_streamer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int W     = W_LANE
) (
  input  logic [WIDTH-1:0] remaining,
  output logic [W-1:0]     mask
);

  localparam int               SH_W  = $clog2(W);
  localparam logic [WIDTH-1:0] W_LEN = WIDTH'(W);

  // Below W only the low SH_W bits of remaining can be non-zero, so they
  // are the whole shift amount.
  always_comb begin
    if (remaining >= W_LEN) begin
      mask = '1;
    end else begin
      mask = ~({W{1'b1}} << remaining[SH_W-1:0]);
    end
  end

endmodule

// File: rtl/squeeze_streamer.sv
// squeeze_streamer: streams the requested number of output bits from the
// rate portion of the Keccak state as W-bit words over valid/ready,
// requesting a permutation whenever a rate block is used up and masking
// the final partial word.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   out_len           - requested output length in bits (sampled on start)
//   start             - begin a request (honoured only when idle)
//   block_size        - rate in bits, multiple of W (sampled on start)
//   rate_word         - rate lane selected by word_idx (combinational)
//   word_idx          - index of the rate lane currently presented
//   perm_req          - one-cycle permutation request pulse
//   perm_done         - permutation complete (honoured only while waiting)
//   dout/dout_valid/dout_ready/dout_last - output word stream
//   busy              - a request is in progress
//   done              - one-cycle pulse when a request completes
module squeeze_streamer
  import squeeze_streamer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int W     = W_LANE,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] out_len,
  input  logic             start,
  input  logic [10:0]      block_size,
  input  logic [W-1:0]     rate_word,
  output logic [IDX_W-1:0] word_idx,
  output logic             perm_req,
  input  logic             perm_done,
  output logic [W-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] W_LEN = WIDTH'(W);
  localparam logic [10:0]      W_BLK = 11'(W);

  squeeze_state_t   state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [10:0]      blk_rem_q, blk_rem_d;
  logic [10:0]      blk_size_q, blk_size_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             perm_req_q, perm_req_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  logic             done_q, done_d;
  logic [W-1:0]     mask;

  word_mask_gen #(
    .WIDTH (WIDTH),
    .W     (W)
  ) u_mask (
    .remaining (remaining_q),
    .mask      (mask)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    blk_rem_d   = blk_rem_q;
    blk_size_d  = blk_size_q;
    word_idx_d  = word_idx_q;
    perm_req_d  = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (out_len == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = out_len;
            blk_rem_d   = block_size;
            blk_size_d  = block_size;
            word_idx_d  = '0;
            state_d     = ST_SQUEEZE;
          end
        end
      end
      ST_SQUEEZE: begin
        if (dout_ready) begin
          remaining_d = (remaining_q < W_LEN) ? '0 : remaining_q - W_LEN;
          blk_rem_d   = blk_rem_q - W_BLK;
          word_idx_d  = word_idx_q + 1'b1;
          // Finishing the request wins over finishing the block, so a
          // request ending exactly on a block boundary needs no permutation.
          if (dout_last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (blk_rem_q == W_BLK) begin
            state_d    = ST_PERMUTE;
            perm_req_d = 1'b1;
          end
        end
      end
      ST_PERMUTE: begin
        state_d = ST_WAIT_PERM;
      end
      ST_WAIT_PERM: begin
        if (perm_done) begin
          word_idx_d = '0;
          blk_rem_d  = blk_size_q;
          state_d    = ST_SQUEEZE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output flags are registered alongside the state they describe.
    dout_valid_d = (state_d == ST_SQUEEZE);
    dout_last_d  = (state_d == ST_SQUEEZE) && (remaining_d <= W_LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      blk_rem_q    <= '0;
      blk_size_q   <= '0;
      word_idx_q   <= '0;
      perm_req_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      blk_rem_q    <= blk_rem_d;
      blk_size_q   <= blk_size_d;
      word_idx_q   <= word_idx_d;
      perm_req_q   <= perm_req_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      done_q       <= done_d;
    end
  end

  // rate_word follows word_idx combinationally, so the masked word is formed
  // here rather than registered; it is forced to zero whenever not valid.
  assign dout       = dout_valid_q ? (rate_word & mask) : '0;
  assign word_idx   = word_idx_q;
  assign perm_req   = perm_req_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule
